// File: rtl/imem_prog_ctrl_if.sv
// Purpose: bundles the fetch, UART and instruction-memory signals of imem_prog_ctrl.
// Latency: none (wiring only).
// Backpressure: none; UART bytes are strobes and are never stalled.
interface imem_prog_ctrl_if;
    logic        prog_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] fetch_addr;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic        memcon_prog_ena;
    logic        prog_busy;
    logic        prog_done;
    logic        prog_err;
    logic [31:0] words_written;

    // Controller side
    modport master (
        input  prog_start, rx_valid, rx_data, fetch_addr, fetch_en,
        output imem_addr, imem_en, imem_we, imem_wdata,
        output memcon_prog_ena, prog_busy, prog_done, prog_err, words_written
    );

    // Environment side (fetch unit, UART, memory, host)
    modport slave (
        output prog_start, rx_valid, rx_data, fetch_addr, fetch_en,
        input  imem_addr, imem_en, imem_we, imem_wdata,
        input  memcon_prog_ena, prog_busy, prog_done, prog_err, words_written
    );
endinterface

// File: rtl/imem_prog_ctrl.sv
// Purpose: arbitrates the imem port between fetch and a UART loader that writes N LE words from BASE_ADDR.
// Latency: prog_start -> memcon_prog_ena 1 cycle; 4th byte of a word -> write strobe 1 cycle.
// Backpressure: none; every UART byte is absorbed. Optional checksum stage: IMEM_PROG_CHECKSUM_EN.
module imem_prog_ctrl #(
    parameter int          IMEM_WORDS     = 4096,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              Rst,
    imem_prog_ctrl_if.master  bus
);

`ifdef IMEM_PROG_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE} state_t;
`endif

    localparam logic [31:0] MAX_WORDS = 32'(IMEM_WORDS);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;       // byte position within the word being assembled
    logic [23:0] asm_q, asm_d;       // bytes 0..2; byte 3 is taken straight from rx_data
    logic [31:0] word_q, word_d;     // completed word presented during WRITE
    logic [31:0] len_q, len_d;
    logic [31:0] ww_q, ww_d;
    logic        err_q, err_d;
    logic [31:0] tmo_q, tmo_d;
    logic        busy_q, busy_d;
`ifdef IMEM_PROG_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic [31:0] full_word;
    logic        last_byte;
    logic        collecting;
    logic        counting;
    logic [31:0] ww_inc;

    // Next-state: byte assembly, session FSM and idle timeout
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        word_d  = word_q;
        len_d   = len_q;
        ww_d    = ww_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
`ifdef IMEM_PROG_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        full_word  = {bus.rx_data, asm_q};
        last_byte  = bus.rx_valid && (idx_q == 2'd3);
        ww_inc     = ww_q + 32'd1;
        collecting = (state_q != S_IDLE) && (state_q != S_DONE);
`ifdef IMEM_PROG_CHECKSUM_EN
        counting   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
`else
        counting   = (state_q == S_LEN) || (state_q == S_DATA);
`endif

        // WRITE also collects, so a byte landing during the write starts the next word
        if (collecting && bus.rx_valid) begin
            case (idx_q)
                2'd0:    asm_d[7:0]   = bus.rx_data;
                2'd1:    asm_d[15:8]  = bus.rx_data;
                2'd2:    asm_d[23:16] = bus.rx_data;
                default: asm_d        = asm_q;
            endcase
            idx_d = idx_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.prog_start) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                    ww_d    = '0;
                    idx_d   = '0;
                    asm_d   = '0;
                    tmo_d   = '0;
`ifdef IMEM_PROG_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            S_LEN: begin
                if (last_byte) begin
                    if (full_word == 32'd0) begin
                        state_d = S_DONE;
                    end else if (full_word > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        len_d   = full_word;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte) begin
                    word_d  = full_word;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                ww_d = ww_inc;
`ifdef IMEM_PROG_CHECKSUM_EN
                sum_d   = sum_q + word_q;
                state_d = (ww_inc == len_q) ? S_CHK : S_DATA;
`else
                state_d = (ww_inc == len_q) ? S_DONE : S_DATA;
`endif
            end
`ifdef IMEM_PROG_CHECKSUM_EN
            S_CHK: begin
                if (last_byte) begin
                    if (full_word != sum_q) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Idle counter: any byte restarts it; expiry abandons the session, keeping written words
        if (counting) begin
            if (bus.rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end else if ((state_q == S_WRITE) && bus.rx_valid) begin
            tmo_d = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State registers with synchronous reset; reset drops any partially assembled word
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            asm_q   <= '0;
            word_q  <= '0;
            len_q   <= '0;
            ww_q    <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
`ifdef IMEM_PROG_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            word_q  <= word_d;
            len_q   <= len_d;
            ww_q    <= ww_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
`ifdef IMEM_PROG_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    // Port mux: fetch owns the memory only while idle
    always_comb begin
        if (state_q == S_IDLE) begin
            bus.imem_addr = bus.fetch_addr;
            bus.imem_en   = bus.fetch_en;
            bus.imem_we   = 1'b0;
        end else begin
            bus.imem_addr = BASE_ADDR + {ww_q[29:0], 2'b00};
            bus.imem_en   = (state_q == S_WRITE);
            bus.imem_we   = (state_q == S_WRITE);
        end
        bus.imem_wdata      = word_q;
        bus.memcon_prog_ena = busy_q;
        bus.prog_busy       = busy_q;
        bus.prog_done       = (state_q == S_DONE);
        bus.prog_err        = err_q;
        bus.words_written   = ww_q;
    end

endmodule

// File: tb/tb_imem_prog_ctrl.sv
// Purpose: directed bench for imem_prog_ctrl with a per-cycle expectation schedule built from the session rules.
// Latency: inputs driven 1 time unit after posedge; outputs compared on negedge.
// Backpressure: none; bytes are streamed back-to-back.
module tb_imem_prog_ctrl;
    localparam int          IW   = 16;
    localparam int          T    = 40;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          NC   = 1024;

    logic clk = 1'b0;
    logic Rst;
    always #5 clk = ~clk;

    imem_prog_ctrl_if bus();

    imem_prog_ctrl #(.IMEM_WORDS(IW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus.master)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Expected per-cycle schedule, indexed by cycle number
    bit        exp_we   [NC];
    bit [31:0] exp_addr [NC];
    bit [31:0] exp_wdata[NC];
    bit        exp_busy [NC];
    bit        exp_done [NC];
    bit        exp_err  [NC];
    bit [31:0] exp_ww   [NC];

    // Observations recorded by the compare process
    int        wr_c[$];
    bit [31:0] wr_a[$];
    bit [31:0] wr_d[$];
    int        done_seen = 0;
    int        done_cyc  = -1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the schedule
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NC) begin
            check32("prog_busy", bus.prog_busy, exp_busy[cyc]);
            check32("memcon_prog_ena", bus.memcon_prog_ena, exp_busy[cyc]);
            check32("prog_done", bus.prog_done, exp_done[cyc]);
            check32("prog_err", bus.prog_err, exp_err[cyc]);
            check32("words_written", bus.words_written, exp_ww[cyc]);
            check32("imem_we", bus.imem_we, exp_we[cyc]);
            if (exp_busy[cyc]) begin
                check32("imem_en_ctrl", bus.imem_en, exp_we[cyc]);
            end else begin
                check32("imem_addr_fetch", bus.imem_addr, bus.fetch_addr);
                check32("imem_en_fetch", bus.imem_en, bus.fetch_en);
            end
            if (exp_we[cyc]) begin
                check32("imem_addr_wr", bus.imem_addr, exp_addr[cyc]);
                check32("imem_wdata", bus.imem_wdata, exp_wdata[cyc]);
            end
            if (bus.imem_we === 1'b1) begin
                wr_c.push_back(cyc);
                wr_a.push_back(bus.imem_addr);
                wr_d.push_back(bus.imem_wdata);
            end
            if (bus.prog_done === 1'b1) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    task automatic fill_level(input int from, input bit err, input bit upd_err,
                              input bit [31:0] ww, input bit upd_ww);
        for (int i = from; i < NC; i++) begin
            if (upd_err) exp_err[i] = err;
            if (upd_ww)  exp_ww[i]  = ww;
        end
    endtask

    // Session outcome from the protocol rules. prog_start in cycle s; byte i in cycle s+1+i,
    // so its effect shows in cycle s+2+i; timeout ends T idle cycles after the last byte.
    task automatic plan(input int s, input bit [7:0] q[$], output int done_c);
        int        nb;
        int        done;
        bit        err;
        int        last_w;
        int        n;
        bit [31:0] nw;
        bit [31:0] sum;
        nb = q.size();
        done = -1; err = 1'b0; last_w = -1; sum = '0;
        fill_level(s + 1, 1'b0, 1'b1, 32'd0, 1'b1);
        if (nb >= 4) begin
            nw = {q[3], q[2], q[1], q[0]};
            if (nw == 32'd0) begin
                done = s + 5;
            end else if (nw > 32'(IW)) begin
                done = s + 5;
                err  = 1'b1;
            end else begin
                n = int'(nw);
                for (int j = 0; j < n; j++) begin
                    int        k;
                    int        w;
                    bit [31:0] word;
                    k = 4 + 4 * j + 3;
                    if (k >= nb) break;
                    w    = s + 1 + k + 1;
                    word = {q[k], q[k-1], q[k-2], q[k-3]};
                    exp_we[w]    = 1'b1;
                    exp_addr[w]  = BASE + 32'(4 * j);
                    exp_wdata[w] = word;
                    sum += word;
                    fill_level(w + 1, 1'b0, 1'b0, 32'(j + 1), 1'b1);
                    if (j == n - 1) last_w = w;
                end
                if (last_w >= 0) begin
`ifdef IMEM_PROG_CHECKSUM_EN
                    int k2;
                    k2 = 4 + 4 * n + 3;
                    if (k2 < nb) begin
                        done = s + 1 + k2 + 1;
                        err  = ({q[k2], q[k2-1], q[k2-2], q[k2-3]} != sum);
                    end
`else
                    done = last_w + 1;
`endif
                end
            end
        end
        if (done < 0) begin
            done = s + nb + 1 + T;
            err  = 1'b1;
        end
        for (int i = s + 1; i <= done; i++) exp_busy[i] = 1'b1;
        exp_done[done] = 1'b1;
        if (err) fill_level(done, 1'b1, 1'b1, 32'd0, 1'b0);
        done_c = done;
    endtask

    task automatic model_reset(input int from);
        for (int i = from; i < NC; i++) begin
            exp_we[i] = 1'b0; exp_busy[i] = 1'b0; exp_done[i] = 1'b0;
            exp_err[i] = 1'b0; exp_ww[i] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic session(input bit [7:0] q[$], input bit do_rst, output int s, output int done_c);
        wr_c.delete(); wr_a.delete(); wr_d.delete();
        done_seen = 0; done_cyc = -1;
        s = cyc;
        plan(s, q, done_c);
        if (done_c > NC - 8) begin
            $display("FAIL schedule cyc=%0d got=%0d expected<%0d", cyc, done_c, NC - 8);
            $fatal(1, "schedule beyond window");
        end
        bus.prog_start = 1'b1;
        tick();
        bus.prog_start = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            bus.rx_valid   = 1'b1;
            bus.rx_data    = q[i];
            bus.fetch_addr = 32'hDEAD_0000 + 32'(i);
            tick();
        end
        bus.rx_valid   = 1'b0;
        bus.fetch_addr = 32'h0000_0080;
        if (do_rst) begin
            Rst = 1'b1;
            model_reset(cyc + 1);
            tick();
            Rst = 1'b0;
        end else begin
            while (cyc < done_c + 2) tick();
        end
    endtask

    task automatic check_reset_values();
        check32("rst_memcon", bus.memcon_prog_ena, 32'd0);
        check32("rst_busy", bus.prog_busy, 32'd0);
        check32("rst_done", bus.prog_done, 32'd0);
        check32("rst_err", bus.prog_err, 32'd0);
        check32("rst_ww", bus.words_written, 32'd0);
        check32("rst_we", bus.imem_we, 32'd0);
        check32("rst_wdata", bus.imem_wdata, 32'd0);
    endtask

    task automatic check_two_words(input int s);
        check32("two_wr_count", 32'(wr_c.size()), 32'd2);
        if (wr_c.size() == 2) begin
            check32("two_wr0_addr", wr_a[0], 32'h0000_0000);
            check32("two_wr0_data", wr_d[0], 32'h0000_0013);
            check32("two_wr0_cyc", 32'(wr_c[0] - s), 32'd9);
            check32("two_wr1_addr", wr_a[1], 32'h0000_0004);
            check32("two_wr1_data", wr_d[1], 32'h0010_0093);
            check32("two_wr1_cyc", 32'(wr_c[1] - s), 32'd13);
        end
        check32("two_done_pulses", 32'(done_seen), 32'd1);
        check32("two_ww", bus.words_written, 32'd2);
        check32("two_err", bus.prog_err, 32'd0);
    endtask

    initial begin
        #(NC * 10 + 100);
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0] q[$];
        bit [7:0] two[$];
        int       s;
        int       d;
        two = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_PROG_CHECKSUM_EN
        two.push_back(8'hA6); two.push_back(8'h00); two.push_back(8'h10); two.push_back(8'h00);
`endif
        Rst = 1'b1;
        bus.prog_start = 1'b0;
        bus.rx_valid   = 1'b0;
        bus.rx_data    = 8'h00;
        bus.fetch_addr = 32'h0000_0040;
        bus.fetch_en   = 1'b1;
        tick(); tick();
        @(negedge clk);
        check_reset_values();
        Rst = 1'b0;
        tick(); tick(); tick();

        // Normal run: fetch owns the port
        @(negedge clk);
        check32("run_addr", bus.imem_addr, 32'h0000_0040);
        check32("run_en", bus.imem_en, 32'd1);
        check32("run_we", bus.imem_we, 32'd0);
        check32("run_memcon", bus.memcon_prog_ena, 32'd0);
        tick();

        // Two-word load
        session(two, 1'b0, s, d);
        check_two_words(s);
        check32("two_memcon_after", bus.memcon_prog_ena, 32'd0);

        // Length above capacity
        q = '{8'h11, 8'h00, 8'h00, 8'h00};
        session(q, 1'b0, s, d);
        check32("ovf_writes", 32'(wr_c.size()), 32'd0);
        check32("ovf_err", bus.prog_err, 32'd1);
        check32("ovf_done_pulses", 32'(done_seen), 32'd1);
        check32("ovf_done_cyc", 32'(done_cyc - s), 32'd5);
        @(negedge clk);
        check32("ovf_port_fetch", bus.imem_addr, 32'h0000_0080);
        tick();

        // Stream stalls mid-load: N=3, five data bytes
        q = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        session(q, 1'b0, s, d);
        check32("tmo_writes", 32'(wr_c.size()), 32'd1);
        if (wr_d.size() > 0) check32("tmo_wr_data", wr_d[0], 32'h4433_2211);
        check32("tmo_err", bus.prog_err, 32'd1);
        check32("tmo_done_pulses", 32'(done_seen), 32'd1);
        check32("tmo_done_cyc", 32'(done_cyc - s), 32'(10 + T));
        check32("tmo_ww", bus.words_written, 32'd1);

        // New session clears the sticky error
        session(two, 1'b0, s, d);
        check_two_words(s);

        // Reset after two data bytes
        q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        session(q, 1'b1, s, d);
        @(negedge clk);
        check_reset_values();
        check32("rstmid_writes", 32'(wr_c.size()), 32'd0);
        tick();

        // Recovery after reset
        session(two, 1'b0, s, d);
        check_two_words(s);

`ifdef IMEM_PROG_CHECKSUM_EN
        // Wrong checksum: both words still land, error raised
        q = two;
        q[12] = 8'hA7;
        session(q, 1'b0, s, d);
        check32("cks_writes", 32'(wr_c.size()), 32'd2);
        check32("cks_err", bus.prog_err, 32'd1);
        check32("cks_done_pulses", 32'(done_seen), 32'd1);
`endif

        tick(); tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imem_prog_ctrl.md
Name: imem_prog_ctrl

Overview:
- Controller and arbiter for the instruction-memory port shared by fetch and the UART reprogramming path.
- In normal run, fetch owns the port.
- On a programming request it takes the port, assembles UART bytes into 32-bit words and writes them sequentially from BASE_ADDR.
- It holds memcon_prog_ena high so fetch sits in reset, then releases fetch so it restarts at PC 0.

Parameters:
- IMEM_WORDS, 4096, capacity of instruction memory in 32-bit words; upper bound on the programmed word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first programmed word.
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between received bytes while loading.

Ports:
- clk  in  1  system clock.
- Rst  in  1  synchronous active-high reset.
- prog_start  in  1  one-cycle request to begin reprogramming.
- rx_valid  in  1  UART byte strobe, one cycle per byte.
- rx_data  in  8  UART byte.
- fetch_addr  in  32  fetch-side instruction address.
- fetch_en  in  1  fetch-side memory enable.
- imem_addr  out  32  address to instruction memory.
- imem_en  out  1  instruction memory enable.
- imem_we  out  1  instruction memory write enable.
- imem_wdata  out  32  write data.
- memcon_prog_ena  out  1  holds fetch in reset while programming.
- prog_busy  out  1  controller owns the port.
- prog_done  out  1  one-cycle completion pulse.
- prog_err  out  1  sticky error flag, cleared on the next accepted prog_start.
- words_written  out  32  count of words written in the current or last session.

Behaviour:
- Reset values: memcon_prog_ena=0, prog_busy=0, prog_done=0, prog_err=0, words_written=0, imem_we=0, imem_wdata=0; state=IDLE. Port mux follows fetch.
- States: IDLE, LEN, DATA, WRITE, CHK (feature only), DONE.
- IDLE:
  - imem_addr=fetch_addr, imem_en=fetch_en, imem_we=0.
  - rx_valid ignored.
  - prog_start=1 -> LEN; clears prog_err and words_written.
- prog_busy and memcon_prog_ena are registered. Both go high the cycle after prog_start and stay high through DONE. Both drop the cycle after DONE.
- In every non-IDLE state the port is driven by the controller, and fetch_addr/fetch_en are ignored.
- Byte assembly:
  - 2-bit byte index; bytes are little-endian (first byte -> bits[7:0]).
  - Index resets to 0 on entry to LEN and after each completed word.
- LEN:
  - 4 bytes form count N.
  - N==0 -> DONE.
  - N>IMEM_WORDS -> prog_err=1, then DONE; no writes.
  - Otherwise -> DATA.
- DATA: on the 4th byte, register the word and go to WRITE.
- WRITE:
  - Exactly one cycle: imem_en=1, imem_we=1, imem_addr=BASE_ADDR+4*words_written, imem_wdata=word.
  - words_written increments at the end of the cycle.
  - A byte arriving during WRITE is captured as byte 0 of the next word; no byte is ever dropped.
  - After the write: if words_written==N -> DONE (or CHK with the feature), else -> DATA.
- Latency:
  - prog_start at t -> memcon_prog_ena at t+1.
  - 4th data byte at t -> write strobe at t+1.
- Timeout:
  - Idle counter runs in LEN/DATA/CHK and clears on each rx_valid.
  - On reaching TIMEOUT_CYCLES: prog_err=1 -> DONE.
  - Words already written stay written.
- DONE: prog_done=1 for one cycle -> IDLE. The port returns to fetch on the next cycle.
- prog_start while not IDLE is ignored.
- Rst mid-session: immediate return to IDLE with reset values. No partial write is issued, and the assembled partial word is discarded.
- Address arithmetic wraps modulo 2^32; words_written is unsigned.

Optional Feature:
- Macro: IMEM_PROG_CHECKSUM_EN.
- Defined: after the last write, go to CHK.
  - CHK takes 4 more bytes holding the expected 32-bit wrapping sum of all N data words.
  - Mismatch sets prog_err=1. CHK -> DONE either way.
  - N==0 skips CHK.
  - A running sum accumulates at each WRITE.
- Undefined: no CHK state and no accumulator; the last WRITE goes directly to DONE.

Test Plan:
- Normal run: fetch_addr=0x40, fetch_en=1, no prog_start -> imem_addr=0x40, imem_en=1, imem_we=0, memcon_prog_ena=0.
- Program 2 words: prog_start; bytes 02 00 00 00, 13 00 00 00, 93 00 10 00 -> writes (0x0, 0x00000013) and (0x4, 0x00100093). Each write lands 1 cycle after its 4th byte. prog_done pulses once; memcon_prog_ena high from the cycle after prog_start until the cycle after DONE; words_written=2.
- Count overflow: N=IMEM_WORDS+1 -> no imem_we, prog_err=1, prog_done pulse, port returns to fetch.
- Timeout: N=3, send 5 bytes then stop -> prog_err=1 after TIMEOUT_CYCLES; exactly 1 word written; prog_done pulses.
- Reset mid-word: Rst asserted after 2 of 4 data bytes -> no write, all outputs at reset values next cycle. A following prog_start session works normally.
- With IMEM_PROG_CHECKSUM_EN: words 0x00000013 and 0x00100093 with checksum 0x001000A6 -> prog_err=0. Checksum 0x001000A7 -> prog_err=1; both writes still performed.
